// File: rtl/note_lane_engine_if.sv
// rtl/note_lane_engine_if.sv - spawn handshake bundle between the pattern source and note_lane_engine
interface note_lane_engine_if #(
  parameter int NUM_LANES = 4
);
  logic                 spawn_valid;
  logic [NUM_LANES-1:0] spawn_mask;
  logic                 spawn_ready;

  modport master (output spawn_valid, output spawn_mask, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_mask, output spawn_ready);
endinterface

// File: rtl/note_lane_engine.sv
// rtl/note_lane_engine.sv - N-lane note scroller with strum judgement, scoring and pixel query (optional STREAK_MULT_EN)
module note_lane_engine #(
  parameter int NUM_LANES      = 4,
  parameter int SLOTS_PER_LANE = 4,
  parameter int Y_W            = 10,
  parameter int SCREEN_H       = 480,
  parameter int NOTE_H         = 50,
  parameter int HIT_Y          = 350,
  parameter int HIT_H          = 20,
  parameter int TICK_DIV       = 1666666,
  parameter int SPEED          = 1,
  parameter int SCORE_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pause,
  note_lane_engine_if.slave    spawn,
  input  logic [NUM_LANES-1:0] strum,
  input  logic [Y_W-1:0]       px_y,
  output logic [NUM_LANES-1:0] lane_active,
  output logic [NUM_LANES-1:0] hit_pulse,
  output logic [NUM_LANES-1:0] miss_pulse,
  output logic [NUM_LANES-1:0] drop_pulse,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           streak
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SLOT_W = (SLOTS_PER_LANE > 1) ? $clog2(SLOTS_PER_LANE) : 1;
  localparam int HC_W   = $clog2(NUM_LANES + 1);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  // Position maths is one bit wider than y so note bottoms and moves never wrap.
  localparam logic [Y_W:0]     NOTE_H_X   = (Y_W+1)'(NOTE_H);
  localparam logic [Y_W:0]     HIT_Y_X    = (Y_W+1)'(HIT_Y);
  localparam logic [Y_W:0]     HIT_END_X  = (Y_W+1)'(HIT_Y + HIT_H);
  localparam logic [Y_W:0]     SCREEN_H_X = (Y_W+1)'(SCREEN_H);
  localparam logic [Y_W:0]     SPEED_X    = (Y_W+1)'(SPEED);

  logic [NUM_LANES-1:0][SLOTS_PER_LANE-1:0] slot_valid;
  logic [Y_W-1:0] slot_y  [NUM_LANES][SLOTS_PER_LANE];
  logic [Y_W:0]   moved_y [NUM_LANES][SLOTS_PER_LANE];

  logic [CNT_W-1:0]     tick_cnt;
  logic                 tick;
  logic [NUM_LANES-1:0] has_free;
  logic [NUM_LANES-1:0] hit_found;
  logic [NUM_LANES-1:0] occupied;
  logic [NUM_LANES-1:0] hit_now;
  logic [NUM_LANES-1:0] miss_now;
  logic [NUM_LANES-1:0] drop_now;
  logic [NUM_LANES-1:0] lane_ok;
  logic [SLOT_W-1:0]    free_idx [NUM_LANES];
  logic [SLOT_W-1:0]    hit_idx  [NUM_LANES];
  logic                 fire;
  logic [HC_W-1:0]      hit_cnt;
  logic [7:0]           score_add;
  logic [SCORE_W+7:0]   score_sum;
  logic [SCORE_W-1:0]   score_next;
  logic [Y_W:0]         px_ext;

  assign px_ext = {1'b0, px_y};
  assign tick   = !pause && (tick_cnt == TICK_LAST);

  // Movement tick divider; pause holds the count so movement resumes in phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!pause) begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  // Per-lane scan of pre-cycle state: free slot, hit candidate, pixel occupancy, moved positions.
  always_comb begin
    logic [Y_W:0] best_y;
    logic [Y_W:0] y_ext;
    logic         found;
    best_y = '0;
    y_ext  = '0;
    found  = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      has_free[l]  = 1'b0;
      free_idx[l]  = '0;
      hit_idx[l]   = '0;
      occupied[l]  = 1'b0;
      found        = 1'b0;
      best_y       = '0;
      // Descending walk so the lowest-index free slot is the one left standing.
      for (int s = SLOTS_PER_LANE - 1; s >= 0; s--) begin
        if (!slot_valid[l][s]) begin
          has_free[l] = 1'b1;
          free_idx[l] = SLOT_W'(s);
        end
      end
      for (int s = 0; s < SLOTS_PER_LANE; s++) begin
        y_ext         = {1'b0, slot_y[l][s]};
        moved_y[l][s] = y_ext + SPEED_X;
        if (slot_valid[l][s]) begin
          // Strictly-greater keeps the lowest index when two candidates share a y.
          if ((y_ext + NOTE_H_X > HIT_Y_X) && (y_ext < HIT_END_X) &&
              (!found || (y_ext > best_y))) begin
            found       = 1'b1;
            hit_idx[l]  = SLOT_W'(s);
            best_y      = y_ext;
          end
          if ((y_ext <= px_ext) && (px_ext < y_ext + NOTE_H_X)) begin
            occupied[l] = 1'b1;
          end
        end
      end
      hit_found[l] = found;
    end
  end

  // Strum judgement and off-screen retirement for this cycle.
  always_comb begin
    hit_now  = strum & hit_found;
    miss_now = strum & ~hit_found;
    drop_now = '0;
    hit_cnt  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      hit_cnt = hit_cnt + HC_W'(hit_now[l]);
      for (int s = 0; s < SLOTS_PER_LANE; s++) begin
        if (slot_valid[l][s] && tick &&
            !(hit_now[l] && (hit_idx[l] == SLOT_W'(s))) &&
            (moved_y[l][s] >= SCREEN_H_X)) begin
          drop_now[l] = 1'b1;
        end
      end
    end
  end

  assign lane_ok           = ~spawn.spawn_mask | has_free;
  assign spawn.spawn_ready = reset && (&lane_ok);
  assign fire              = spawn.spawn_valid && spawn.spawn_ready;

`ifdef STREAK_MULT_EN
  logic [7:0] streak_q;
  logic [2:0] mult;
  logic [8:0] streak_sum;

  assign mult       = (streak_q >= 8'd30) ? 3'd4 : 3'd1 + 3'(streak_q / 8'd10);
  assign streak_sum = {1'b0, streak_q} + 9'(hit_cnt);
  assign score_add  = 8'(hit_cnt) * 8'(mult);
  assign streak     = streak_q;

  // Consecutive-hit counter; any miss or drop in any lane breaks the run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      streak_q <= '0;
    end else if ((|miss_now) || (|drop_now)) begin
      streak_q <= '0;
    end else if (streak_sum > 9'd255) begin
      streak_q <= 8'hFF;
    end else begin
      streak_q <= streak_sum[7:0];
    end
  end
`else
  assign score_add = 8'(hit_cnt);
  assign streak    = '0;
`endif

  assign score_sum  = (SCORE_W+8)'(score) + (SCORE_W+8)'(score_add);
  assign score_next = (|score_sum[SCORE_W+7:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];

  // Slot update: a hit clears first, then movement/retirement, then spawning into a free slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_valid <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int s = 0; s < SLOTS_PER_LANE; s++) begin
          slot_y[l][s] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int s = 0; s < SLOTS_PER_LANE; s++) begin
          if (hit_now[l] && (hit_idx[l] == SLOT_W'(s))) begin
            slot_valid[l][s] <= 1'b0;
          end else if (slot_valid[l][s] && tick) begin
            if (moved_y[l][s] >= SCREEN_H_X) begin
              slot_valid[l][s] <= 1'b0;
            end else begin
              slot_y[l][s] <= moved_y[l][s][Y_W-1:0];
            end
          end else if (fire && spawn.spawn_mask[l] && !slot_valid[l][s] &&
                       (free_idx[l] == SLOT_W'(s))) begin
            slot_valid[l][s] <= 1'b1;
            slot_y[l][s]     <= '0;
          end
        end
      end
    end
  end

  // Registered event pulses, pixel query result and score.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_pulse   <= '0;
      miss_pulse  <= '0;
      drop_pulse  <= '0;
      lane_active <= '0;
      score       <= '0;
    end else begin
      hit_pulse   <= hit_now;
      miss_pulse  <= miss_now;
      drop_pulse  <= drop_now;
      lane_active <= occupied;
      score       <= score_next;
    end
  end

endmodule

// File: doc/note_lane_engine.md
Name: note_lane_engine

Overview:
- Parametrised note-track engine for the Guitar Hero VGA path. Replaces hard-wired per-lane position arrays with N lanes × M slots, a spawn handshake, a tick-driven scroller, strum hit/miss judgement, scoring, and a registered per-pixel lane-occupancy query.
- Sits between the song/pattern source (spawn side) and the VGA colour mux, which consumes lane_active.

Parameters:
- NUM_LANES, 4, number of note lanes.
- SLOTS_PER_LANE, 4, maximum simultaneous notes per lane.
- Y_W, 10, width of note y-position and pixel y.
- SCREEN_H, 480, notes with y >= SCREEN_H are retired.
- NOTE_H, 50, note height in pixels.
- HIT_Y, 350, top row of the hit bar.
- HIT_H, 20, hit bar height.
- TICK_DIV, 1666666, clk cycles per movement tick (60 Hz at 100 MHz).
- SPEED, 1, pixels moved per tick.
- SCORE_W, 16, score width.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- pause  in  1  high freezes tick counter and movement.
- spawn_valid  in  1  spawn request.
- spawn_mask  in  NUM_LANES  lanes receiving a new note.
- spawn_ready  out  1  engine can accept spawn_mask this cycle.
- strum  in  NUM_LANES  one-cycle strum pulse per lane.
- px_y  in  Y_W  current scan y.
- lane_active  out  NUM_LANES  px_y lies inside a valid note in that lane (1-cycle latency).
- hit_pulse  out  NUM_LANES  strum judged a hit.
- miss_pulse  out  NUM_LANES  strum with no note in the hit zone.
- drop_pulse  out  NUM_LANES  note retired off-screen unhit.
- score  out  SCORE_W  accumulated score.
- streak  out  8  consecutive-hit count (only with STREAK_MULT_EN).

Behaviour:
- Reset (reset==0 at posedge clk): all slots invalid, tick counter 0, score 0, streak 0, all pulses 0, lane_active 0. spawn_ready is forced 0 while reset is low.
- Slot state: valid bit plus unsigned y[Y_W-1:0]. y is the note's top edge.
- Tick: the counter counts 0..TICK_DIV-1 when pause==0. tick asserts for one cycle at wrap. pause holds the counter value.
- Move: on tick, every valid slot does y <= y + SPEED.
  - If the new y >= SCREEN_H, the slot is cleared instead and drop_pulse[lane] is 1 the next cycle.
  - Addition is performed at Y_W+1 bits, so there is no wrap.
- Spawn handshake: spawn_ready = 1 when every lane set in spawn_mask has at least one free slot.
  - Transfer occurs when spawn_valid && spawn_ready. Each masked lane allocates its lowest-index free slot with y=0.
  - spawn_mask==0 with valid is accepted as a no-op.
  - A new note is not moved by a tick in the same cycle.
  - The source holds valid/mask until ready.
- Hit zone: a slot is in-zone when (y + NOTE_H > HIT_Y) && (y < HIT_Y + HIT_H), evaluated on pre-tick positions.
- Strum on lane L:
  - If any in-zone valid slot exists, clear the in-zone slot with the largest y (lowest index on tie). hit_pulse[L]=1 next cycle and score increments. A cleared slot is not moved or dropped that cycle.
  - Otherwise miss_pulse[L]=1 next cycle and score is unchanged.
- Multiple lanes strummed in one cycle are judged independently. Score adds the total hit count in a single update.
- Score saturates at all-ones.
- Simultaneous spawn and hit/drop in one lane: free-slot computation uses pre-cycle state. A slot freed this cycle is not reusable until the next cycle.
- lane_active[L] is registered: 1 if any valid slot satisfies y <= px_y < y + NOTE_H, sampled on pre-update state.
- Pulses are single-cycle and registered.
- Reset mid-operation clears everything within the same cycle, regardless of pending spawn or strum.

Optional Feature:
- Macro: STREAK_MULT_EN.
- Defined:
  - Per-lane hits increment streak, saturating at 255.
  - Any miss_pulse or drop_pulse event clears streak to 0.
  - Each hit adds multiplier = min(1 + streak/10, 4), using the streak value before the update. Multiple hits in one cycle all use that same multiplier.
- Undefined: each hit adds 1 and streak is tied to 0.

Test Plan:
- Reset and spawn: TICK_DIV=2, release reset, spawn_mask=4'b0101 -> slots lane0/lane2 valid y=0; spawn_ready stays 1; 5 more 4'b0001 spawns -> spawn_ready=0 after 4 in lane0 is reached (SLOTS_PER_LANE=4), 4'b0010 still ready.
- Scroll and drop: one lane0 note, SPEED=10, TICK_DIV=2 -> y advances 10 every 2 cycles; drop_pulse[0] for exactly one cycle when y reaches 480 (48th tick); slot freed.
- Hit: lane1 note advanced to y=310 (in zone: 360>350, 310<370), strum=4'b0010 -> hit_pulse[1]=1, score 0->1, slot cleared, lane_active[1] never asserts afterward.
- Miss: note at y=200, strum lane1 -> miss_pulse[1]=1, score unchanged, note continues to drop.
- Pixel query: note lane3 y=100, px_y sweep 99/100/149/150 -> lane_active[3] = 0/1/1/0, each one cycle after px_y.
- Streak (STREAK_MULT_EN): 10 consecutive hits -> score 10; 11th hit adds 2 (score 12); then a drop -> streak 0 and next hit adds 1.
